// File: rtl/dds_pkg.sv
// Shared widths and loader state encoding for the DDS phase path.
// Latency: none (types and constants only).
// Backpressure: none.
package dds_pkg;

    localparam int ACC_W_DEF   = 24;
    localparam int PHASE_W_DEF = 14;
    localparam int CFG_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYTE1  = 2'd1,
        BYTE2  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    typedef enum logic {
        SEL_FTW  = 1'b0,
        SEL_POFF = 1'b1
    } cfg_sel_t;

endpackage

// File: rtl/dds_cfg_loader.sv
// Byte-serial loader: three MSB-first bytes into a shadow, then atomic copy to FTW or POFF.
// Latency: active register updates on the edge closing COMMIT, one cycle after the third byte.
// Backpressure: cfg_ready drops only during the COMMIT cycle.
module dds_cfg_loader
    import dds_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CFG_W = CFG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_sel,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic [ACC_W-1:0] ftw,
    output logic [ACC_W-1:0] poff
);

    generate
        if (ACC_W != 3 * CFG_W) begin : g_bad_width
            $error("dds_cfg_loader: ACC_W must equal 3*CFG_W");
        end
    endgenerate

    cfg_state_t       state;
    cfg_sel_t         sel_q;
    logic [ACC_W-1:0] shadow;
    logic [ACC_W-1:0] shadow_shifted;
    logic             accept;

    assign accept         = cfg_valid && cfg_ready;
    assign shadow_shifted = {shadow[ACC_W-CFG_W-1:0], cfg_data};

    // cfg_ready and cfg_done are registered alongside the state so they
    // track it exactly: both change on the edge that enters or leaves COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= SEL_FTW;
            shadow    <= '0;
            ftw       <= '0;
            poff      <= '0;
            cfg_ready <= 1'b1;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shadow <= shadow_shifted;
                        sel_q  <= cfg_sel_t'(cfg_sel);
                        state  <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (accept) begin
                        shadow <= shadow_shifted;
                        state  <= BYTE2;
                    end
                end
                BYTE2: begin
                    if (accept) begin
                        shadow    <= shadow_shifted;
                        state     <= COMMIT;
                        cfg_ready <= 1'b0;
                        cfg_done  <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (sel_q == SEL_POFF) begin
                        poff <= shadow;
                    end else begin
                        ftw <= shadow;
                    end
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: acc += FTW per enabled cycle, phase = top bits of (acc + POFF).
// Latency: phase, wrap and phase_valid are registered together on the accumulate edge.
// Backpressure: none on the datapath; the loader never stalls accumulation.
module dds_phase_accumulator
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int CFG_W   = CFG_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_sync,
    input  logic [CFG_W-1:0]   cfg_data,
    input  logic               cfg_sel,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_done,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap
);

    generate
        if (PHASE_W > ACC_W) begin : g_bad_phase_w
            $error("dds_phase_accumulator: PHASE_W must not exceed ACC_W");
        end
    endgenerate

    logic [ACC_W-1:0] ftw;
    logic [ACC_W-1:0] poff;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_upd;
    logic [ACC_W-1:0] phase_sum;
    logic             carry;

    dds_cfg_loader #(
        .ACC_W (ACC_W),
        .CFG_W (CFG_W)
    ) u_cfg_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_data  (cfg_data),
        .cfg_sel   (cfg_sel),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .ftw       (ftw),
        .poff      (poff)
    );

    // Phase is derived from the value acc is about to take, so the phase
    // register and the wrap pulse describe the same accumulator sample.
    always_comb begin
        {carry, acc_sum} = {1'b0, acc} + {1'b0, ftw};
        acc_upd          = phase_sync ? '0 : acc_sum;
        phase_sum        = acc_upd + poff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            phase_valid <= en || phase_sync;
            if (phase_sync) begin
                acc   <= '0;
                phase <= phase_sum[ACC_W-1 -: PHASE_W];
                wrap  <= 1'b0;
            end else if (en) begin
                acc   <= acc_sum;
                phase <= phase_sum[ACC_W-1 -: PHASE_W];
                wrap  <= carry;
            end else begin
                wrap  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator with hand-computed expectations.
module tb_dds_phase_accumulator;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        en         = 1'b0;
    logic        phase_sync = 1'b0;
    logic [7:0]  cfg_data   = 8'h00;
    logic        cfg_sel    = 1'b0;
    logic        cfg_valid  = 1'b0;
    logic        cfg_ready;
    logic        cfg_done;
    logic [13:0] phase;
    logic        phase_valid;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    logic [7:0] stream [6] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h14, 8'h00};

    always #5 clk = ~clk;

    dds_phase_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .phase_sync  (phase_sync),
        .cfg_data    (cfg_data),
        .cfg_sel     (cfg_sel),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_done    (cfg_done),
        .phase       (phase),
        .phase_valid (phase_valid),
        .wrap        (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s);
        int n = 0;
        cfg_data  = b;
        cfg_sel   = s;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 8) begin
            tick();
            n++;
        end
        chk("rdy_wait_expired", 32'(n >= 8), 0);
        tick();
        cfg_valid = 1'b0;
    endtask

    // sel is flipped on bytes 2 and 3 to show it is only latched on byte 1.
    task automatic load_word(input logic [23:0] w, input logic s, input string tag);
        send_byte(w[23:16], s);
        send_byte(w[15:8], ~s);
        send_byte(w[7:0], ~s);
        chk({tag, "_done"}, cfg_done, 1);
        tick();
        chk({tag, "_done_clr"}, cfg_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drop_mask;
        int         idx;
        int         dones;
        logic       rdy;

        repeat (2) @(negedge clk);
        chk("rst_phase", phase, 0);
        chk("rst_valid", phase_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_done", cfg_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // FTW 0x000400 -> one phase LSB per cycle
        load_word(24'h000400, 1'b0, "ftw400");
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("inc_phase", phase, 32'(i));
            chk("inc_valid", phase_valid, 1);
            chk("inc_wrap", wrap, 0);
        end

        // sync wins over en
        phase_sync = 1'b1;
        tick();
        chk("sync_phase", phase, 0);
        chk("sync_wrap", wrap, 0);
        chk("sync_valid", phase_valid, 1);
        phase_sync = 1'b0;
        en         = 1'b0;
        tick();
        chk("hold_valid", phase_valid, 0);
        chk("hold_phase", phase, 0);

        // FTW 0x800000 -> half-cycle steps, wrap every other cycle
        load_word(24'h800000, 1'b0, "ftw800k");
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("half_phase", phase, (i % 2 == 0) ? 32'h2000 : 32'h0);
            chk("half_wrap", wrap, (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        en = 1'b0;
        tick();
        chk("idle_wrap", wrap, 0);
        chk("idle_phase", phase, 0);

        // FTW 0, POFF quarter turn
        load_word(24'h000000, 1'b0, "ftw0");
        load_word(24'h400000, 1'b1, "poff");
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("poff_phase", phase, 32'h1000);
            chk("poff_wrap", wrap, 0);
        end
        en = 1'b0;

        // reset in the middle of a word
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("arst_phase", phase, 0);
        chk("arst_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h00, 1'b0);
        chk("rl_b1_done", cfg_done, 0);
        send_byte(8'h08, 1'b0);
        chk("rl_b2_done", cfg_done, 0);
        send_byte(8'h00, 1'b0);
        chk("rl_b3_done", cfg_done, 1);
        tick();
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rl_phase", phase, 32'(2 * i));
        end
        en = 1'b0;

        // streaming config with cfg_valid held high
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        drop_mask  = 8'h00;
        idx        = 0;
        dones      = 0;
        for (int c = 0; c < 8; c++) begin
            cfg_valid = (idx < 6);
            cfg_data  = stream[(idx < 6) ? idx : 5];
            cfg_sel   = 1'b0;
            rdy       = cfg_ready;
            if (!rdy) drop_mask[c] = 1'b1;
            if (cfg_done) dones++;
            tick();
            if (rdy && cfg_valid) idx++;
        end
        cfg_valid = 1'b0;
        chk("stream_drops", drop_mask, 8'b1000_1000);
        chk("stream_dones", dones, 2);
        chk("stream_bytes", idx, 6);
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("stream_phase", phase, 32'(5 * i));
        end
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
